// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequencing controller for an external bank of T flip-flops.
// Drives per-bit toggle enables from bank feedback so the bank counts up or
// down by one per cycle to a latched limit, pulses done, or clears on abort.
// Optional feature macro: TFF_COUNT_CTRL_AUTORELOAD_EN (DONE -> RELOAD -> COUNT).
module tff_count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

`ifdef TFF_COUNT_CTRL_AUTORELOAD_EN
  localparam int unsigned SW = 3;
`else
  localparam int unsigned SW = 2;
`endif

  typedef enum logic [SW-1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE,
    S_CLEAR
`ifdef TFF_COUNT_CTRL_AUTORELOAD_EN
    , S_RELOAD
`endif
  } state_t;

  state_t           state, state_nx;
  logic             dir, dir_nx;
  logic [WIDTH-1:0] lim, lim_nx;
  logic [WIDTH-1:0] up_tv, dn_tv, lo_mask;

  // Toggle vectors for +1 / -1: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    up_tv   = '0;
    dn_tv   = '0;
    lo_mask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      lo_mask  = WIDTH'((64'd1 << i) - 64'd1);
      up_tv[i] = &(q_fb | ~lo_mask);
      dn_tv[i] = ~|(q_fb & lo_mask);
    end
  end

  // State, direction and limit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      dir   <= 1'b1;
      lim   <= '0;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
      lim   <= lim_nx;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    lim_nx   = lim;
    t_vec    = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (abort) begin
          state_nx = S_CLEAR;
        end else if (start) begin
          dir_nx   = up_dn;
          lim_nx   = limit;
          state_nx = S_COUNT;
        end
      end
      S_COUNT: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = S_CLEAR;
        end else if (q_fb == lim) begin
          state_nx = S_DONE;
        end else begin
          t_vec = dir ? up_tv : dn_tv;
        end
      end
      S_DONE: begin
        done = 1'b1;
`ifdef TFF_COUNT_CTRL_AUTORELOAD_EN
        state_nx = S_RELOAD;
`else
        state_nx = S_IDLE;
`endif
      end
      S_CLEAR: begin
        busy     = 1'b1;
        t_vec    = q_fb;
        state_nx = S_IDLE;
      end
`ifdef TFF_COUNT_CTRL_AUTORELOAD_EN
      S_RELOAD: begin
        busy     = 1'b1;
        t_vec    = q_fb;
        state_nx = abort ? S_CLEAR : S_COUNT;
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/tff_count_ctrl.md
Name: tff_count_ctrl

Overview:
- Sequencing controller for an external bank of WIDTH T flip-flops. The bank uses the team's clk/reset/t/q flip-flop cell.
- Each cycle it drives per-bit toggle enables (t_vec) from bank feedback (q_fb), so the bank counts up or down from its current value to a latched limit.
- On reaching the limit it pulses done. It can also clear the bank to zero on abort.
- Sits between a host FSM (start/abort/limit) and the flip-flop bank.

Parameters:
- WIDTH, 4, number of T flip-flops in the controlled bank.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset; sampled on the rising clk edge.
- start, input, 1, request a count run; sampled only in IDLE.
- up_dn, input, 1, direction: 1 = up, 0 = down; latched with start.
- limit, input, WIDTH, terminal value; latched with start.
- abort, input, 1, cancel run and clear the bank to 0.
- q_fb, input, WIDTH, current Q outputs of the flip-flop bank.
- t_vec, output, WIDTH, toggle enables to the bank (combinational from state, dir and q_fb).
- busy, output, 1, high in COUNT or CLEAR.
- done, output, 1, high for exactly one cycle in DONE.

Behaviour:
- Reset: state=IDLE, dir=1, lim=0. Outputs: t_vec=0, busy=0, done=0. Reset has priority over every other input.
- States: IDLE, COUNT, DONE, CLEAR; state register is binary-encoded.
- IDLE
  - t_vec=0.
  - start=1 and abort=0: latch dir<=up_dn and lim<=limit; go to COUNT.
  - abort=1: go to CLEAR; abort wins over start.
- COUNT (busy=1)
  - Priority: abort > terminal > count.
  - abort=1: t_vec=0; go to CLEAR.
  - Terminal (q_fb==lim): t_vec=0; go to DONE.
  - Otherwise, up: t_vec[0]=1; t_vec[i]=&q_fb[i-1:0].
  - Otherwise, down: t_vec[0]=1; t_vec[i]=~|q_fb[i-1:0].
  - The bank therefore moves by exactly ±1 per cycle. Wrap-around is natural modulo 2^WIDTH (up from all-ones gives 0; down from 0 gives all-ones).
- DONE
  - t_vec=0, done=1, busy=0.
  - Next state IDLE; abort is ignored here.
- CLEAR (busy=1)
  - t_vec=q_fb, which toggles every set bit, so the bank reads 0 after one edge.
  - Next state IDLE.
- start outside IDLE is ignored. limit and up_dn changes after latching are ignored until the next start.
- Latency:
  - First bank change occurs on the edge after entry to COUNT, i.e. 2 edges after start is sampled.
  - A run of N steps takes N COUNT cycles plus 1 terminal-detect cycle, then 1 DONE cycle.
- start with q_fb already equal to limit: zero steps; done pulses 2 edges after start is sampled.
- reset mid-run: forces IDLE and t_vec=0 at that edge. The bank is reset by its own reset; the controller makes no assumption about the q_fb value after reset.

Optional Feature:
- Macro: TFF_COUNT_CTRL_AUTORELOAD_EN.
- Defined: DONE goes to a RELOAD state instead of IDLE.
  - RELOAD behaves like CLEAR (t_vec=q_fb, busy=1), then enters COUNT with the same dir and lim, giving periodic runs without start.
  - done still pulses once per run.
  - abort in COUNT or RELOAD goes to CLEAR, then IDLE.
- Undefined: no RELOAD state; DONE always returns to IDLE.

Test Plan:
- WIDTH=4, bank reset to 0, start=1 up_dn=1 limit=5 for one cycle -> q_fb steps 1,2,3,4,5 on successive edges; t_vec=0 while q_fb=5; done high one cycle; busy low afterwards.
- q_fb=0, start up_dn=0 limit=13 -> q_fb goes 15,14,13; done pulses once; t_vec=4'b1111 on the first step.
- Up run with limit=9 from q_fb=0; assert abort when q_fb=6 -> next cycle in CLEAR with t_vec=4'b0110; q_fb=0 after that edge; IDLE; done never asserts.
- Start with q_fb=3, limit=3 -> no toggles; done pulses 2 edges after start; start pulses during COUNT/DONE of another run are ignored.
- Assert reset during COUNT at q_fb=2 -> t_vec=0, busy=0, done=0 from that edge; a later start begins a fresh run. With TFF_COUNT_CTRL_AUTORELOAD_EN defined and limit=2 up: done pulses repeatedly with a constant period until abort.
